// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared constants and types for the six-stage pipeline control unit:
// stage indices, stall-vector patterns, controller FSM encoding and the
// stall-priority encoder helper.
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    // Pipeline geometry
    localparam int unsigned NUM_STAGES = 6;

    // Stage indices into the stall vector
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    // Default widths of the core
    localparam int unsigned MXLEN        = 64;
    localparam int unsigned CNT_W_DEF    = 32;
    localparam int unsigned TIMEOUT_DEF  = 1024;

    typedef logic [NUM_STAGES-1:0] stall_t;

    // Each pattern holds the requesting stage and everything upstream of it;
    // the single 1->0 boundary is where the bubble is inserted.
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_IF   = 6'b000011;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam stall_t STALL_MEM  = 6'b011111;

    // Controller FSM: RUN normally, DRAIN while a stale fetch is outstanding
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Highest (most downstream) stall request wins
    function automatic stall_t encode_stall(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        stall_t s;
        if (req_mem)     s = STALL_MEM;
        else if (req_ex) s = STALL_EX;
        else if (req_id) s = STALL_ID;
        else if (req_if) s = STALL_IF;
        else             s = STALL_NONE;
        return s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle between the pipeline stages and the central control unit.
//   master : pipeline side - drives stall requests, exception and branch
//            redirects; receives stall/flush/redirect/discard/watchdog/perf.
//   slave  : control unit side - the reverse directions.
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
);

    // Requests from the stages
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              excp_valid;
    logic [XLEN-1:0]   excp_vector;
    logic              branch_valid;
    logic [XLEN-1:0]   branch_target;

    // Control back to the stages
    logic [5:0]        stall;
    logic              flush;
    logic              new_pc_valid;
    logic [XLEN-1:0]   new_pc;
    logic              if_discard;
    logic              bus_timeout;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_vector, branch_valid, branch_target,
        input  stall, flush, new_pc_valid, new_pc, if_discard,
        input  bus_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_vector, branch_valid, branch_target,
        output stall, flush, new_pc_valid, new_pc, if_discard,
        output bus_timeout, stall_cycles
    );

endinterface

// File: rtl/pipeline_ctrl_bus_watchdog.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_bus_watchdog
// Counts consecutive MEM stall cycles; after TIMEOUT_CYCLES of them it emits
// a registered one-cycle timeout pulse and restarts from zero.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   mem_busy   : MEM stage waiting on the D-bus
//   flush      : pipeline flush this cycle (abandons the wait)
//   timeout    : one-cycle pulse on expiry
// ----------------------------------------------------------------------------
module pipeline_ctrl_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_busy,
    input  logic flush,
    output logic timeout
);

    // Counter only needs to reach TIMEOUT_CYCLES-1
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] cnt;
    logic            expire;

    // Expiry on the last counted cycle of an uninterrupted wait
    assign expire = mem_busy & ~flush & (cnt == WD_LAST);

    // Counter and pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (!mem_busy || flush || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + WD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Central control for the PC/IF/ID/EX/MEM/WB in-order pipeline.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipeline_ctrl_if.slave
//     in  stallreq_if/id/ex/mem  per-stage stall requests
//     in  excp_valid/excp_vector trap committed at MEM and its target
//     in  branch_valid/target    taken branch resolved in ID
//     out stall[5:0]             per-stage hold (0=PC .. 5=WB), combinational
//     out flush                  clear all pipeline registers, combinational
//     out new_pc_valid/new_pc    redirect into pc_reg, combinational
//     out if_discard             IF drops the next I-bus response
//     out bus_timeout            registered D-bus watchdog pulse
//     out stall_cycles           cycles with a non-zero stall vector
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = MXLEN,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus
);

    state_t           state;
    state_t           state_nxt;
    stall_t           stall_enc;
    stall_t           stall_c;
    logic             branch_acc;
    logic             redirect;
    logic             flush_c;
    logic             new_pc_valid_c;
    logic [XLEN-1:0]  new_pc_c;
    logic             if_discard_c;
    logic             timeout;
    logic [CNT_W-1:0] stall_cnt;

    // Raw priority-encoded stall, before the exception override
    assign stall_enc = encode_stall(bus.stallreq_if, bus.stallreq_id,
                                    bus.stallreq_ex, bus.stallreq_mem);

    // A branch sitting in a held ID stage is re-presented later
    assign branch_acc = bus.branch_valid & ~bus.excp_valid & ~stall_enc[STG_ID];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and zero-latency control outputs; everything is 0 in reset
    always_comb begin
        state_nxt      = state;
        stall_c        = STALL_NONE;
        flush_c        = 1'b0;
        new_pc_valid_c = 1'b0;
        new_pc_c       = '0;
        if_discard_c   = 1'b0;
        redirect       = 1'b0;

        if (!rst) begin
            if (bus.excp_valid) begin
                flush_c        = 1'b1;
                new_pc_valid_c = 1'b1;
                new_pc_c       = bus.excp_vector;
            end else begin
                stall_c = stall_enc;
                if (branch_acc) begin
                    new_pc_valid_c = 1'b1;
                    new_pc_c       = bus.branch_target;
                end
            end

            redirect = new_pc_valid_c;

            // A fetch still in flight at redirect time returns stale data
            case (state)
                ST_RUN: begin
                    if (redirect && bus.stallreq_if) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if_discard_c = 1'b1;
                    if (!bus.stallreq_if && !redirect) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Stall performance counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_c != STALL_NONE) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // D-bus watchdog; a flush abandons the pending access
    pipeline_ctrl_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk      (clk),
        .rst      (rst),
        .mem_busy (bus.stallreq_mem),
        .flush    (flush_c),
        .timeout  (timeout)
    );

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_c;
    assign bus.new_pc_valid = new_pc_valid_c;
    assign bus.new_pc       = new_pc_c;
    assign bus.if_discard   = if_discard_c;
    assign bus.bus_timeout  = timeout;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed scenarios followed by random traffic, every cycle compared against
// a behavioural reference model of the control unit.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

    pipeline_ctrl #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    bit          m_drain;
    int          m_wd;
    bit          m_to;
    logic [31:0] m_cnt;

    int n_cmp;
    int n_err;
    int pulses;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the model over the rising edge and check registered outputs.
    task automatic step(input logic r, input logic i_if, input logic i_id,
                        input logic i_ex, input logic i_mem, input logic i_ev,
                        input logic [63:0] vec, input logic i_bv,
                        input logic [63:0] bt);
        logic [5:0]  e_stall;
        logic        e_flush;
        logic        e_npv;
        logic        e_disc;
        logic        acc;
        logic [63:0] e_npc;

        @(negedge clk);
        rst               = r;
        bus.stallreq_if   = i_if;
        bus.stallreq_id   = i_id;
        bus.stallreq_ex   = i_ex;
        bus.stallreq_mem  = i_mem;
        bus.excp_valid    = i_ev;
        bus.excp_vector   = vec;
        bus.branch_valid  = i_bv;
        bus.branch_target = bt;
        #1;

        e_stall = 6'd0;
        e_flush = 1'b0;
        e_npv   = 1'b0;
        e_npc   = 64'd0;
        e_disc  = 1'b0;
        acc     = 1'b0;
        if (!r) begin
            if (i_ev) begin
                e_flush = 1'b1;
                e_npv   = 1'b1;
                e_npc   = vec;
            end else begin
                if (i_mem)     e_stall = 6'b011111;
                else if (i_ex) e_stall = 6'b001111;
                else if (i_id) e_stall = 6'b000111;
                else if (i_if) e_stall = 6'b000011;
                acc = i_bv && !(i_id || i_ex || i_mem);
                if (acc) begin
                    e_npv = 1'b1;
                    e_npc = bt;
                end
            end
            e_disc = m_drain;
        end

        check("stall",        64'(bus.stall),        64'(e_stall));
        check("flush",        64'(bus.flush),        64'(e_flush));
        check("new_pc_valid", 64'(bus.new_pc_valid), 64'(e_npv));
        check("new_pc",       bus.new_pc,            e_npc);
        check("if_discard",   64'(bus.if_discard),   64'(e_disc));

        @(posedge clk);
        if (r) begin
            m_drain = 1'b0;
            m_wd    = 0;
            m_to    = 1'b0;
            m_cnt   = 32'd0;
        end else begin
            if (m_drain) m_drain = i_if || i_ev || acc;
            else         m_drain = (i_ev || acc) && i_if;
            m_to = 1'b0;
            if (i_mem && !i_ev) begin
                if (m_wd == int'(TO) - 1) begin
                    m_to = 1'b1;
                    m_wd = 0;
                end else begin
                    m_wd++;
                end
            end else begin
                m_wd = 0;
            end
            if (e_stall != 6'd0) m_cnt = m_cnt + 32'd1;
        end
        #1;
        check("bus_timeout",  64'(bus.bus_timeout),  64'(m_to));
        check("stall_cycles", 64'(bus.stall_cycles), 64'(m_cnt));
        if (bus.bus_timeout) pulses++;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pulses  = 0;
        m_drain = 1'b0;
        m_wd    = 0;
        m_to    = 1'b0;
        m_cnt   = 32'd0;

        // Reset with requests active: everything forced low
        step(1, 1, 1, 1, 1, 1, 64'h1234, 1, 64'h5678);
        step(1, 0, 0, 0, 0, 0, 64'h0,    0, 64'h0);

        // Priority: id+mem, then id, then idle
        step(0, 0, 1, 0, 1, 0, 64'h0, 0, 64'h0);
        step(0, 0, 1, 0, 0, 0, 64'h0, 0, 64'h0);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        check("perf_after_priority", 64'(bus.stall_cycles), 64'd2);

        // Exception beats a same-cycle branch
        step(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1, 64'h8000_0040);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);

        // Branch held by EX stall, accepted once EX clears
        step(0, 0, 0, 1, 0, 0, 64'h0, 1, 64'h8000_0040);
        step(0, 0, 0, 0, 0, 0, 64'h0, 1, 64'h8000_0040);

        // Branch with fetch outstanding: drain 3 cycles + return cycle
        step(0, 1, 0, 0, 0, 0, 64'h0, 1, 64'h8000_2000);
        step(0, 1, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        step(0, 1, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        step(0, 1, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);

        // Watchdog: 9 MEM stall cycles give two pulses
        pulses = 0;
        for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        check("wd_pulses_9", 64'(pulses), 64'd2);

        // Released before expiry: no pulse
        pulses = 0;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
        check("wd_pulses_short", 64'(pulses), 64'd0);

        // Reset mid-DRAIN with watchdog at 2, then a full timeout is needed
        step(0, 1, 0, 0, 0, 0, 64'h0, 1, 64'h8000_3000);
        step(0, 1, 0, 0, 1, 0, 64'h0, 0, 64'h0);
        step(0, 1, 0, 0, 1, 0, 64'h0, 0, 64'h0);
        step(1, 1, 0, 0, 1, 0, 64'h0, 0, 64'h0);
        check("perf_after_reset", 64'(bus.stall_cycles), 64'd0);
        pulses = 0;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
        check("wd_after_reset_3", 64'(pulses), 64'd0);
        step(0, 0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
        check("wd_after_reset_4", 64'(pulses), 64'd1);
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 14) == 0,
                 {$urandom(), $urandom()},
                 $urandom_range(0, 3) == 0,
                 {$urandom(), $urandom()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
